// File: rtl/mpi_pkg.sv
// Shared definitions for the multi-channel MPI receive buffer:
// register offsets, STATUS/CTRL bit positions and per-channel status.
package mpi_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_SIZE   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_AVAIL   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_IE      = 0;
    localparam int CTRL_DROP    = 1;
    localparam int CTRL_CLR_OVF = 2;

    typedef struct packed {
        logic [7:0] pkt_cnt;
        logic       ovf;
        logic       full;
        logic       avail;
    } chan_status_t;

    function automatic logic [15:0] status_word(chan_status_t s);
        logic [15:0] w;
        w                    = '0;
        w[ST_AVAIL]          = s.avail;
        w[ST_FULL]           = s.full;
        w[ST_OVF]            = s.ovf;
        w[ST_CNT_LSB +: 8]   = s.pkt_cnt;
        return w;
    endfunction

endpackage

// File: rtl/mpi_buffer_mc_if.sv
// NoC ingress and register-bus signal bundle for mpi_buffer_mc.
// slave = the buffer, master = whatever drives the ingress ports and the bus.
interface mpi_buffer_mc_if #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int CHANNELS       = 2
);
    logic [CHANNELS*NOC_FLIT_WIDTH-1:0] noc_in_flit;
    logic [CHANNELS-1:0]                noc_in_last;
    logic [CHANNELS-1:0]                noc_in_valid;
    logic [CHANNELS-1:0]                noc_in_ready;
    logic                               bus_en;
    logic                               bus_we;
    logic [7:0]                         bus_addr;
    logic [NOC_FLIT_WIDTH-1:0]          bus_wdata;
    logic [NOC_FLIT_WIDTH-1:0]          bus_rdata;
    logic                               bus_ack;
    logic                               irq;

    modport slave (
        input  noc_in_flit, noc_in_last, noc_in_valid,
        input  bus_en, bus_we, bus_addr, bus_wdata,
        output noc_in_ready, bus_rdata, bus_ack, irq
    );

    modport master (
        output noc_in_flit, noc_in_last, noc_in_valid,
        output bus_en, bus_we, bus_addr, bus_wdata,
        input  noc_in_ready, bus_rdata, bus_ack, irq
    );
endinterface

// File: rtl/mpi_channel_buffer.sv
// One receive channel: flit FIFO + packet-length FIFO, oversize truncation, drop, OVF/IE.
// Latency: packet visible one cycle after its last flit; DATA pop takes effect at the access edge.
// Backpressure: ready = !flit_full, except an oversize packet's tail is always accepted and discarded.
module mpi_channel_buffer
    import mpi_pkg::*;
#(
    parameter int W    = 32,
    parameter int SIZE = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] flit,
    input  logic         last,
    input  logic         valid,
    output logic         ready,
    input  logic         pop_req,
    input  logic         ctrl_wr,
    input  logic [2:0]   ctrl_wdata,
    output logic [W-1:0] head_flit,
    output logic [W-1:0] remaining,
    output chan_status_t status,
    output logic         ie
);
    localparam int AW = $clog2(SIZE);
    localparam int LW = $clog2(SIZE + 1);
    localparam logic [LW-1:0] SIZE_L = LW'(SIZE);

    logic [W-1:0]  flit_mem [SIZE];
    logic [LW-1:0] len_mem  [SIZE];
    logic [AW-1:0] wr_ptr, rd_ptr, len_wr, len_rd;
    logic [LW-1:0] flit_cnt, len_cnt, wr_len, rem;
    logic          rem_loaded, ovf, rst_done;

    logic          flit_full, oversize, acc, push_flit, commit, avail, pop, drop, len_pop;
    logic [LW-1:0] commit_len, remaining_l, rem_next, flit_dec;

    always_comb begin
        flit_full   = (flit_cnt == SIZE_L);
        oversize    = (wr_len == SIZE_L);
        ready       = rst_done & (oversize | ~flit_full);
        acc         = valid & ready;
        push_flit   = acc & ~oversize;
        commit      = acc & last;
        commit_len  = oversize ? SIZE_L : wr_len + LW'(1);
        avail       = (len_cnt != '0);
        // The head count is consumed directly until the first pop latches a running copy.
        remaining_l = rem_loaded ? rem : (avail ? len_mem[len_rd] : '0);
        pop         = pop_req & avail;
        drop        = ctrl_wr & ctrl_wdata[CTRL_DROP] & avail;
        rem_next    = remaining_l - LW'(1);
        len_pop     = drop | (pop & (rem_next == '0));
        flit_dec    = drop ? remaining_l : LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rst_done   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            flit_cnt   <= '0;
            len_wr     <= '0;
            len_rd     <= '0;
            len_cnt    <= '0;
            wr_len     <= '0;
            rem        <= '0;
            rem_loaded <= 1'b0;
            ovf        <= 1'b0;
            ie         <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (push_flit) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr   <= rd_ptr + AW'(flit_dec);
            flit_cnt <= flit_cnt + LW'(push_flit) - flit_dec;

            if (commit) begin
                len_wr <= len_wr + AW'(1);
                wr_len <= '0;
            end else if (push_flit) begin
                wr_len <= wr_len + LW'(1);
            end
            len_rd  <= len_rd + AW'(len_pop);
            len_cnt <= len_cnt + LW'(commit) - LW'(len_pop);

            if (len_pop) begin
                rem_loaded <= 1'b0;
            end else if (pop) begin
                rem        <= rem_next;
                rem_loaded <= 1'b1;
            end

            if (acc && oversize)                       ovf <= 1'b1;
            else if (ctrl_wr && ctrl_wdata[CTRL_CLR_OVF]) ovf <= 1'b0;

            if (ctrl_wr) ie <= ctrl_wdata[CTRL_IE];
        end
    end

    always_ff @(posedge clk) begin
        if (push_flit) flit_mem[wr_ptr] <= flit;
        if (commit)    len_mem[len_wr]  <= commit_len;
    end

    assign head_flit      = flit_mem[rd_ptr];
    assign remaining      = W'(remaining_l);
    assign status.pkt_cnt = 8'(len_cnt);
    assign status.ovf     = ovf;
    assign status.full    = flit_full;
    assign status.avail   = avail;

endmodule

// File: rtl/mpi_buffer_mc.sv
// Multi-channel packet-level NoC receive buffer behind a single-cycle register bus.
// Latency: bus_ack and registered bus_rdata one cycle after bus_en; one access per cycle sustained.
// Backpressure: per-channel noc_in_ready from each channel's flit FIFO; the bus never stalls.
module mpi_buffer_mc
    import mpi_pkg::*;
#(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int SIZE           = 16,
    parameter int CHANNELS       = 2
) (
    input logic            clk,
    input logic            rst,
    mpi_buffer_mc_if.slave mpi
);
    localparam int W = NOC_FLIT_WIDTH;

    chan_status_t        st       [CHANNELS];
    logic [W-1:0]        head     [CHANNELS];
    logic [W-1:0]        rem      [CHANNELS];
    logic [CHANNELS-1:0] rdy_v, ie_v, avail_v, data_rd, ctrl_wr;
    logic [3:0]          acc_ch;
    logic [1:0]          acc_reg;
    logic [W-1:0]        rd_val;

    assign acc_ch  = mpi.bus_addr[7:4];
    assign acc_reg = mpi.bus_addr[3:2];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        mpi_channel_buffer #(
            .W    (W),
            .SIZE (SIZE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .flit       (mpi.noc_in_flit[g*W +: W]),
            .last       (mpi.noc_in_last[g]),
            .valid      (mpi.noc_in_valid[g]),
            .ready      (rdy_v[g]),
            .pop_req    (data_rd[g]),
            .ctrl_wr    (ctrl_wr[g]),
            .ctrl_wdata (mpi.bus_wdata[2:0]),
            .head_flit  (head[g]),
            .remaining  (rem[g]),
            .status     (st[g]),
            .ie         (ie_v[g])
        );
        assign avail_v[g] = st[g].avail;
    end

    // Channels at or above CHANNELS never match, so they read 0 and ignore writes.
    always_comb begin
        rd_val  = '0;
        data_rd = '0;
        ctrl_wr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (acc_ch == 4'(c)) begin
                case (acc_reg)
                    REG_DATA:   rd_val = st[c].avail ? head[c] : '0;
                    REG_SIZE:   rd_val = rem[c];
                    REG_STATUS: rd_val = W'(status_word(st[c]));
                    default:    rd_val[CTRL_IE] = ie_v[c];
                endcase
                data_rd[c] = mpi.bus_en & ~mpi.bus_we & (acc_reg == REG_DATA);
                ctrl_wr[c] = mpi.bus_en &  mpi.bus_we & (acc_reg == REG_CTRL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mpi.bus_ack   <= 1'b0;
            mpi.bus_rdata <= '0;
        end else begin
            mpi.bus_ack   <= mpi.bus_en;
            mpi.bus_rdata <= (mpi.bus_en && !mpi.bus_we) ? rd_val : '0;
        end
    end

    assign mpi.noc_in_ready = rdy_v;
    assign mpi.irq          = |(ie_v & avail_v);

endmodule
